// File: rtl/mul_wb_scheduler_pkg.sv
// Shared types for the multiplier writeback scheduler.
// Holds the FSM state encoding and default widths.
// No logic; imported by the scheduler and its dependency checker.
package mul_wb_scheduler_pkg;

  // Register-address width used by the ARM register file (r0..r15)
  localparam int RA_W_DEF = 4;

  // Countdown width; covers MUL_LAT up to 15
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_wb_scheduler_dep_check.sv
// Compares D-stage register operands against the in-flight MUL destination.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its busy state.
module mul_dep_check #(
  parameter int RA_W = 4
) (
  input  logic [RA_W-1:0] ra1_d,
  input  logic [RA_W-1:0] ra2_d,
  input  logic [RA_W-1:0] wa3_d,
  input  logic            reg_write_d,
  input  logic [RA_W-1:0] pend_rd,
  output logic            raw,
  output logic            waw
);

  // Read-after-write on either source, write-after-write only if D really writes
  always_comb begin
    raw = (ra1_d == pend_rd) | (ra2_d == pend_rd);
    waw = reg_write_d & (wa3_d == pend_rd);
  end

endmodule

// File: rtl/mul_wb_scheduler.sv
// Sequences the multi-cycle multiplier, tracks its destination and owns RF-port arbitration.
// Issue at t writes at t+MUL_LAT at the earliest; every W-stage write collision adds one cycle.
// Pipeline W stage always wins the write port; F/D stall while a dependent instruction waits.
module mul_wb_scheduler
  import mul_wb_scheduler_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int RA_W    = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mul_issue_e,
  input  logic [RA_W-1:0] mul_rd_e,
  input  logic            mul_d,
  input  logic [RA_W-1:0] ra1_d,
  input  logic [RA_W-1:0] ra2_d,
  input  logic [RA_W-1:0] wa3_d,
  input  logic            reg_write_d,
  input  logic            reg_write_w,
  output logic            mul_start,
  output logic            mul_busy,
  output logic            rf_we_mul,
  output logic [RA_W-1:0] rf_wa_mul,
  output logic            wb_sel_mul,
  output logic            stall_fd,
  output logic            bubble_e,
  output logic            mul_err
);

  // Counter load: RUN occupies MUL_LAT-1 cycles, WB is the final one
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  mul_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RA_W-1:0]  pend_rd_q, pend_rd_d;
  logic             mul_err_q, mul_err_d;
  logic             wr_grant;
  logic             raw, waw;

  mul_dep_check #(.RA_W(RA_W)) u_dep_check (
    .ra1_d       (ra1_d),
    .ra2_d       (ra2_d),
    .wa3_d       (wa3_d),
    .reg_write_d (reg_write_d),
    .pend_rd     (pend_rd_q),
    .raw         (raw),
    .waw         (waw)
  );

  // Next-state logic: issue, countdown, and write-port grant
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    mul_err_d = mul_err_q | (mul_issue_e & (state_q != IDLE));
    mul_start = 1'b0;
    wr_grant  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mul_issue_e) begin
          mul_start = 1'b1;
          pend_rd_d = mul_rd_e;
          cnt_d     = CNT_INIT;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Saturating decrement; the result is valid as the count leaves 1
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) state_d = WB;
      end
      WB: begin
        // Datapath holds its result, so losing the port just costs a cycle
        if (!reg_write_w) begin
          wr_grant = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_rd_q <= '0;
      mul_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
      mul_err_q <= mul_err_d;
    end
  end

  // Output decode; hazards only matter once pend_rd holds a live MUL
  always_comb begin
    mul_busy   = (state_q != IDLE);
    rf_we_mul  = wr_grant;
    wb_sel_mul = wr_grant;
    rf_wa_mul  = mul_busy ? pend_rd_q : '0;
    stall_fd   = mul_busy & (raw | waw | mul_d);
    bubble_e   = stall_fd;
    mul_err    = mul_err_q;
  end

endmodule

// File: tb/tb_mul_wb_scheduler.sv
// Directed bench for the MUL writeback scheduler.
// Two instances: MUL_LAT=4 for the main scenarios, MUL_LAT=2 for the short corner.
// Inputs driven 1 ns after posedge, outputs sampled 4 ns after posedge.
module tb_mul_wb_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mul_issue_e, mul_d, reg_write_d, reg_write_w;
  logic [3:0] mul_rd_e, ra1_d, ra2_d, wa3_d;
  logic       issue2;
  logic [3:0] rd2;

  logic       mul_start, mul_busy, rf_we_mul, wb_sel_mul, stall_fd, bubble_e, mul_err;
  logic [3:0] rf_wa_mul;
  logic       start2, busy2, we2, sel2, stall2, bub2, err2;
  logic [3:0] wa2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_wb_scheduler #(.MUL_LAT(4), .RA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mul_issue_e(mul_issue_e), .mul_rd_e(mul_rd_e),
    .mul_d(mul_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .reg_write_d(reg_write_d), .reg_write_w(reg_write_w),
    .mul_start(mul_start), .mul_busy(mul_busy), .rf_we_mul(rf_we_mul),
    .rf_wa_mul(rf_wa_mul), .wb_sel_mul(wb_sel_mul), .stall_fd(stall_fd),
    .bubble_e(bubble_e), .mul_err(mul_err)
  );

  mul_wb_scheduler #(.MUL_LAT(2), .RA_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .mul_issue_e(issue2), .mul_rd_e(rd2),
    .mul_d(mul_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .wa3_d(wa3_d),
    .reg_write_d(reg_write_d), .reg_write_w(reg_write_w),
    .mul_start(start2), .mul_busy(busy2), .rf_we_mul(we2),
    .rf_wa_mul(wa2), .wb_sel_mul(sel2), .stall_fd(stall2),
    .bubble_e(bub2), .mul_err(err2)
  );

  // Advance to the drive point of the next cycle
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling
  task automatic settle;
    #3;
  endtask

  task automatic clear_inputs;
    mul_issue_e = 0; mul_rd_e = 0; mul_d = 0; ra1_d = 0; ra2_d = 0;
    wa3_d = 0; reg_write_d = 0; reg_write_w = 0; issue2 = 0; rd2 = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    #12;
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL reset_start got %b want 0", mul_start); end
    checks++; if (mul_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", mul_busy); end
    checks++; if (rf_we_mul !== 1'b0 || wb_sel_mul !== 1'b0) begin errors++; $display("FAIL reset_we got %b/%b want 0/0", rf_we_mul, wb_sel_mul); end
    checks++; if (rf_wa_mul !== 4'd0) begin errors++; $display("FAIL reset_wa got %0d want 0", rf_wa_mul); end
    checks++; if (stall_fd !== 1'b0 || bubble_e !== 1'b0) begin errors++; $display("FAIL reset_stall got %b/%b want 0/0", stall_fd, bubble_e); end
    checks++; if (mul_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", mul_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Reset asserted while the MUL is in RUN: nothing must be written afterwards
  task automatic test_reset_mid_run;
    int we_seen;
    clear_inputs();
    mul_issue_e = 1; mul_rd_e = 4'd5;                       // cycle 0
    settle();
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL midrst_start got %b want 1", mul_start); end
    tick(); mul_issue_e = 0;                                // cycle 1
    settle();
    checks++; if (mul_busy !== 1'b1 || rf_wa_mul !== 4'd5) begin errors++; $display("FAIL midrst_busy got %b/%0d want 1/5", mul_busy, rf_wa_mul); end
    tick(); rst_n = 1'b0;                                   // cycle 2
    settle();
    checks++; if (mul_busy !== 1'b0 || rf_wa_mul !== 4'd0 || stall_fd !== 1'b0) begin errors++; $display("FAIL midrst_clear got busy=%b wa=%0d stall=%b want 0/0/0", mul_busy, rf_wa_mul, stall_fd); end
    tick(); rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 6; c++) begin
      settle();
      if (rf_we_mul !== 1'b0 || mul_busy !== 1'b0) we_seen++;
      tick();
    end
    checks++; if (we_seen != 0) begin errors++; $display("FAIL midrst_no_write got %0d active cycles want 0", we_seen); end
  endtask

  // MUL_LAT=4, free port: write at t0+4, idle at t0+5
  task automatic test_basic;
    clear_inputs();
    mul_issue_e = 1; mul_rd_e = 4'd3;                       // t0
    settle();
    checks++; if (mul_start !== 1'b1 || mul_busy !== 1'b0) begin errors++; $display("FAIL basic_t0 got start=%b busy=%b want 1/0", mul_start, mul_busy); end
    for (int c = 1; c <= 3; c++) begin
      tick(); mul_issue_e = 0;
      settle();
      checks++; if (mul_busy !== 1'b1 || rf_we_mul !== 1'b0 || mul_start !== 1'b0) begin errors++; $display("FAIL basic_run t0+%0d got busy=%b we=%b start=%b want 1/0/0", c, mul_busy, rf_we_mul, mul_start); end
    end
    tick(); settle();                                       // t0+4
    checks++; if (rf_we_mul !== 1'b1 || wb_sel_mul !== 1'b1 || rf_wa_mul !== 4'd3) begin errors++; $display("FAIL basic_write got we=%b sel=%b wa=%0d want 1/1/3", rf_we_mul, wb_sel_mul, rf_wa_mul); end
    tick(); settle();                                       // t0+5
    checks++; if (mul_busy !== 1'b0 || rf_we_mul !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b we=%b want 0/0", mul_busy, rf_we_mul); end
    tick();
  endtask

  // W stage takes the port at t0+4 and t0+5; MUL writes at t0+6, stall held meanwhile
  task automatic test_conflict;
    clear_inputs();
    mul_issue_e = 1; mul_rd_e = 4'd3; ra1_d = 4'd3;         // t0, hazard present but IDLE
    settle();
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL conf_issue_nostall got %b want 0", stall_fd); end
    tick(); mul_issue_e = 0; tick(); tick(); tick();        // t0+4
    reg_write_w = 1;
    settle();
    checks++; if (rf_we_mul !== 1'b0 || stall_fd !== 1'b1) begin errors++; $display("FAIL conf_t4 got we=%b stall=%b want 0/1", rf_we_mul, stall_fd); end
    tick(); settle();                                       // t0+5
    checks++; if (rf_we_mul !== 1'b0 || mul_busy !== 1'b1 || stall_fd !== 1'b1) begin errors++; $display("FAIL conf_t5 got we=%b busy=%b stall=%b want 0/1/1", rf_we_mul, mul_busy, stall_fd); end
    tick(); reg_write_w = 0; settle();                      // t0+6
    checks++; if (rf_we_mul !== 1'b1 || rf_wa_mul !== 4'd3 || stall_fd !== 1'b1) begin errors++; $display("FAIL conf_t6 got we=%b wa=%0d stall=%b want 1/3/1", rf_we_mul, rf_wa_mul, stall_fd); end
    tick(); settle();                                       // t0+7
    checks++; if (mul_busy !== 1'b0 || stall_fd !== 1'b0) begin errors++; $display("FAIL conf_t7 got busy=%b stall=%b want 0/0", mul_busy, stall_fd); end
    tick();
  endtask

  // RAW on ra2_d stalls t0+1..t0+4; unrelated operands never stall
  task automatic test_raw;
    clear_inputs();
    mul_issue_e = 1; mul_rd_e = 4'd7; ra1_d = 4'd1; ra2_d = 4'd7;
    settle();
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL raw_t0 got %b want 0", stall_fd); end
    for (int c = 1; c <= 4; c++) begin
      tick(); mul_issue_e = 0; settle();
      checks++; if (stall_fd !== 1'b1 || bubble_e !== 1'b1) begin errors++; $display("FAIL raw_stall t0+%0d got %b/%b want 1/1", c, stall_fd, bubble_e); end
    end
    checks++; if (rf_we_mul !== 1'b1) begin errors++; $display("FAIL raw_write got %b want 1", rf_we_mul); end
    tick(); settle();
    checks++; if (stall_fd !== 1'b0 || bubble_e !== 1'b0) begin errors++; $display("FAIL raw_release got %b/%b want 0/0", stall_fd, bubble_e); end
    tick();
    mul_issue_e = 1; mul_rd_e = 4'd7; ra1_d = 4'd2; ra2_d = 4'd2; wa3_d = 4'd9; reg_write_d = 1;
    for (int c = 0; c <= 4; c++) begin
      settle();
      checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL raw_nohaz t0+%0d got %b want 0", c, stall_fd); end
      tick(); mul_issue_e = 0;
    end
  endtask

  // WAW stall, MUL-in-D stall, illegal second issue sets sticky error
  task automatic test_waw_back_to_back;
    clear_inputs();
    mul_issue_e = 1; mul_rd_e = 4'd7;                       // t0
    tick(); mul_issue_e = 0; wa3_d = 4'd7; reg_write_d = 1; // t0+1
    settle();
    checks++; if (stall_fd !== 1'b1) begin errors++; $display("FAIL waw_stall got %b want 1", stall_fd); end
    tick(); reg_write_d = 0; mul_d = 1; mul_issue_e = 1; mul_rd_e = 4'd4; // t0+2
    settle();
    checks++; if (stall_fd !== 1'b1) begin errors++; $display("FAIL muld_stall got %b want 1", stall_fd); end
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL busy_issue_start got %b want 0", mul_start); end
    tick(); mul_issue_e = 0; mul_d = 0; settle();           // t0+3
    checks++; if (stall_fd !== 1'b0) begin errors++; $display("FAIL waw_nowrite_nostall got %b want 0", stall_fd); end
    checks++; if (mul_err !== 1'b1 || rf_wa_mul !== 4'd7) begin errors++; $display("FAIL err_set got err=%b wa=%0d want 1/7", mul_err, rf_wa_mul); end
    tick(); settle();                                       // t0+4
    checks++; if (rf_we_mul !== 1'b1 || rf_wa_mul !== 4'd7) begin errors++; $display("FAIL b2b_write got we=%b wa=%0d want 1/7", rf_we_mul, rf_wa_mul); end
    tick(); tick(); settle();
    checks++; if (mul_err !== 1'b1 || mul_busy !== 1'b0) begin errors++; $display("FAIL err_sticky got err=%b busy=%b want 1/0", mul_err, mul_busy); end
    rst_n = 1'b0; settle();
    checks++; if (mul_err !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", mul_err); end
    tick(); rst_n = 1'b1; tick();
  endtask

  // MUL_LAT=2: write at t0+2, new issue accepted at t0+3
  task automatic test_lat2;
    clear_inputs();
    issue2 = 1; rd2 = 4'd6;                                 // t0
    settle();
    checks++; if (start2 !== 1'b1) begin errors++; $display("FAIL lat2_start got %b want 1", start2); end
    tick(); issue2 = 0; settle();                           // t0+1
    checks++; if (busy2 !== 1'b1 || we2 !== 1'b0) begin errors++; $display("FAIL lat2_run got busy=%b we=%b want 1/0", busy2, we2); end
    tick(); settle();                                       // t0+2
    checks++; if (we2 !== 1'b1 || sel2 !== 1'b1 || wa2 !== 4'd6) begin errors++; $display("FAIL lat2_write got we=%b sel=%b wa=%0d want 1/1/6", we2, sel2, wa2); end
    tick(); issue2 = 1; rd2 = 4'd8; settle();               // t0+3
    checks++; if (busy2 !== 1'b0 || start2 !== 1'b1) begin errors++; $display("FAIL lat2_reissue got busy=%b start=%b want 0/1", busy2, start2); end
    tick(); issue2 = 0; settle();
    checks++; if (busy2 !== 1'b1 || wa2 !== 4'd8) begin errors++; $display("FAIL lat2_second_run got busy=%b wa=%0d want 1/8", busy2, wa2); end
    tick(); settle();
    checks++; if (we2 !== 1'b1 || wa2 !== 4'd8) begin errors++; $display("FAIL lat2_second_write got we=%b wa=%0d want 1/8", we2, wa2); end
    checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL lat2_err got %b want 0", err2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_basic();
    test_conflict();
    test_raw();
    test_waw_back_to_back();
    test_lat2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
